// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV M-extension execute unit.
// The multiplier delivers its product MUL_LATENCY cycles after accept.
// The divider is a radix-2 restoring divider that works on operand magnitudes.
// It finishes with one sign-fix cycle.
module muldiv_unit #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW      = $clog2(XLEN + 1);
    localparam int MUL_CNT = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;      // mul operand A, or dividend magnitude shifting into quotient
    logic [XLEN-1:0] b_q;      // mul operand B, or divisor magnitude
    logic [XLEN-1:0] rem_q;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] result_q;

    logic idle_like, accept, busy;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept    = start_i & ~flush_i & idle_like;
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

    // Divide operand preparation at accept time.
    logic            div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    assign div_sgn  = ~op_i[0];
    assign a_neg    = div_sgn & src_a_i[XLEN-1];
    assign b_neg    = div_sgn & src_b_i[XLEN-1];
    assign a_mag    = a_neg ? (~src_a_i + 1'b1) : src_a_i;
    assign b_mag    = b_neg ? (~src_b_i + 1'b1) : src_b_i;
    assign div_zero = (src_b_i == '0);
    assign div_ovf  = div_sgn && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b_i);
    // op_i[1] selects remainder (REM/REMU) over quotient.
    assign special_res = div_zero ? (op_i[1] ? src_a_i : '1)
                                  : (op_i[1] ? '0 : src_a_i);

    // Multiplier is fed from the inputs at accept (latency 1),
    // and from the captured operands while in MUL.
    logic [2:0]        mul_op;
    logic [XLEN-1:0]   mul_a, mul_b, mul_res;
    logic              ma_sgn, mb_sgn;
    logic [XLEN:0]     ma_ext, mb_ext;
    logic [2*XLEN+1:0] prod_full;
    assign mul_op    = (state_q == S_MUL) ? op_q : op_i;
    assign mul_a     = (state_q == S_MUL) ? a_q  : src_a_i;
    assign mul_b     = (state_q == S_MUL) ? b_q  : src_b_i;
    assign ma_sgn    = (mul_op == 3'b001) || (mul_op == 3'b010);
    assign mb_sgn    = (mul_op == 3'b001);
    assign ma_ext    = {ma_sgn & mul_a[XLEN-1], mul_a};
    assign mb_ext    = {mb_sgn & mul_b[XLEN-1], mul_b};
    assign prod_full = {{(XLEN+1){ma_ext[XLEN]}}, ma_ext} * {{(XLEN+1){mb_ext[XLEN]}}, mb_ext};
    assign mul_res   = (mul_op == 3'b000) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];

    // One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin, fix_res;
    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, b_q};
    assign ge      = ~diff[XLEN+1];
    assign rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {a_q[XLEN-2:0], ge};
    assign quo_fin = neg_quo_q ? (~a_q + 1'b1) : a_q;
    assign rem_fin = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    assign fix_res = op_q[1] ? rem_fin : quo_fin;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: flush aborts any in-flight op; DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (!op_i[2])               state_d = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
                    else if (div_zero | div_ovf) state_d = S_DONE;
                    else                         state_d = S_DIV;
                end
            end
            S_MUL: if (flush_i) state_d = S_IDLE; else if (cnt_q == '0) state_d = S_DONE;
            S_DIV: if (flush_i) state_d = S_IDLE; else if (cnt_q == '0) state_d = S_FIX;
            S_FIX: state_d = flush_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate, and load the result on the way into DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op_i;
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (!op_i[2]) begin
                a_q   <= src_a_i;
                b_q   <= src_b_i;
                cnt_q <= CW'(MUL_CNT);
                if (MUL_LATENCY == 1) result_q <= mul_res;
            end else begin
                a_q   <= a_mag;
                b_q   <= b_mag;
                cnt_q <= CW'(XLEN - 1);
                if (div_zero | div_ovf) result_q <= special_res;
            end
        end else if (!flush_i) begin
            unique case (state_q)
                S_MUL: begin
                    if (cnt_q == '0) result_q <= mul_res;
                    else             cnt_q    <= cnt_q - 1'b1;
                end
                S_DIV: begin
                    a_q   <= quo_nx;
                    rem_q <= rem_nx;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_FIX:   result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign stall_req_o = rst_n_i & (accept | busy);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32, MUL_LATENCY=2).
// Expected results come from a 64-bit behavioural model.
// They are queued at issue and popped on each done pulse.
module tb_muldiv_unit;
    localparam int XL      = 32;
    localparam int MUL_LAT = 2;

    logic          clk, rst_n, start, flush;
    logic [2:0]    op;
    logic [XL-1:0] src_a, src_b;
    logic          stall_req, done;
    logic [XL-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XL-1:0] exp_q[$];

    muldiv_unit #(.XLEN(XL), .MUL_LATENCY(MUL_LAT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
        .stall_req_o(stall_req), .done_o(done), .result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XL-1:0] ref_op(input logic [2:0] o, input logic [XL-1:0] a, input logic [XL-1:0] b);
        longint sa, sb, ua, ub, r;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = 0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: begin r = sa * sb; r = r >>> 32; end
            3'd2: begin r = sa * ub; r = r >>> 32; end
            3'd3: begin pu = longint'(ua) * longint'(ub); r = longint'(pu >> 32); end
            3'd4: r = (b == 0) ? -1 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb);
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb);
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[XL-1:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [XL-1:0] a, input logic [XL-1:0] b);
        if (!o[2]) return MUL_LAT - 1;
        if (b == 0) return 0;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return XL + 1;
    endfunction

    // Issue one op, then follow it to done.
    // Checks stall while busy, latency in edges after accept, the result,
    // stall low in the DONE cycle, and a single-cycle done.
    task automatic run_op(input logic [2:0] o, input logic [XL-1:0] a, input logic [XL-1:0] b, input string name);
        int k, lat;
        bit seen, bad_stall;
        logic [XL-1:0] e;
        lat = exp_lat(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        exp_q.push_back(ref_op(o, a, b));
        #1;
        n_checks++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall got=%b want=1", name, stall_req); end
        @(posedge clk); #1 start = 1'b0;
        k = 0; seen = 0; bad_stall = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else begin
                if (stall_req !== 1'b1) bad_stall = 1;
                @(posedge clk); k++;
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s timeout no done within 100 cycles", name); end
        else begin
            if (bad_stall) $display("FAIL %s busy_stall dropped before done", name);
            if (bad_stall) n_fail++;
            n_checks++;
            if (k != lat) begin n_fail++; $display("FAIL %s latency got=%0d want=%0d", name, k, lat); end
            n_checks++;
            if (result !== e) begin n_fail++; $display("FAIL %s result got=%h want=%h", name, result, e); end
            n_checks++;
            if (stall_req !== 1'b0) begin n_fail++; $display("FAIL %s done_stall got=%b want=0", name, stall_req); end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got=%b want=0", name, done); end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        #12;
        n_checks++;
        if (done !== 1'b0 || result !== '0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_state done=%b result=%h stall=%b want 0/0/0", done, result, stall_req);
        end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(3'd0, 32'h1234_5678, 32'h0000_0010, "mul_low");
        run_op(3'd2, 32'hFFFF_FFFE, 32'h8000_0000, "mulhsu_neg");
    endtask

    task automatic test_div_signed;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        run_op(3'd4, 32'd100, 32'hFFFF_FFF9, "div_negdivisor");
    endtask

    task automatic test_div_zero;
        run_op(3'd5, 32'd5, 32'd0, "divu_zero");
        run_op(3'd7, 32'd5, 32'd0, "remu_zero");
        run_op(3'd4, 32'hFFFF_FFF0, 32'd0, "div_zero");
    endtask

    task automatic test_overflow;
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divu_noovf");
    endtask

    task automatic test_flush;
        logic [XL-1:0] held;
        int dones;
        bit bad;
        @(negedge clk);
        held = result; start = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;              // accept edge T
        repeat (9) @(posedge clk);                    // edge T+9
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;                           // edge T+10
        n_checks++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b want=0", stall_req); end
        @(negedge clk); flush = 1'b0;
        dones = 0; bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (stall_req !== 1'b0) bad = 1;
        end
        n_checks++;
        if (dones != 0 || bad) begin n_fail++; $display("FAIL flush_nodone dones=%0d stall_seen=%b want 0/0", dones, bad); end
        n_checks++;
        if (result !== held) begin n_fail++; $display("FAIL flush_result got=%h want=%h", result, held); end
        // flush together with start: the op must not be accepted
        @(negedge clk); start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || stall_req !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL flush_start_accepted got=1 want=0"); end
        run_op(3'd5, 32'd100, 32'd7, "divu_after_flush");
        run_op(3'd7, 32'd100, 32'd7, "remu_after_flush");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        @(posedge clk); #2 rst_n = 1'b0;              // in MUL, start still high
        #1;
        n_checks++;
        if (done !== 1'b0 || result !== '0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid done=%b result=%h stall=%b want 0/0/0", done, result, stall_req);
        end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_nodone got=%b want=0", done); end
    endtask

    task automatic test_back_to_back;
        logic [XL-1:0] e;
        @(negedge clk);
        start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        exp_q.push_back(32'd12);
        @(posedge clk); #1 src_a = 32'd5; src_b = 32'd6;   // held start is ignored in MUL
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_first_early got=%b want=0", done); end
        @(posedge clk); #1;                                 // now in DONE
        exp_q.push_back(32'd30);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || result !== e) begin n_fail++; $display("FAIL b2b_first done=%b result=%h want 1/%h", done, result, e); end
        n_checks++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall got=%b want=1", stall_req); end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b want=0", done); end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || result !== e) begin n_fail++; $display("FAIL b2b_second done=%b result=%h want 1/%h", done, result, e); end
    endtask

    task automatic test_random;
        logic [2:0] o;
        logic [XL-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) b = 32'd3;
            run_op(o, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for XLEN-bit operands.
- Sits beside the ALU in the execute stage. Raises a stall request to the hazard unit while an operation is in flight and returns one result per accepted op.
- Replaces single-cycle combinational M-ops with:
  - a registered multiplier of configurable latency;
  - an iterative radix-2 restoring divider;
  - flush/abort support.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_LATENCY, 2, cycles from accept to multiply result; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new op (an M-type instruction is in execute).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  XLEN  rs1 operand, after forwarding.
- src_b  input  XLEN  rs2 operand, after forwarding.
- flush  input  1  abort any in-flight op (branch taken / flush_e).
- stall_req  output  1  hold F/D/E stages.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  operation result; held until the next accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; done=0; result=0; all internal counters and operand registers cleared.
  - stall_req=0 while rst_n=0.
  - Reset mid-operation discards the op with no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept:
  - An op is accepted on a rising edge where start=1, flush=0 and state is IDLE or DONE.
  - start while in MUL, DIV or FIX is ignored. The unit captures op, src_a and src_b only on accept.
- stall_req is combinational:
  - (start & ~flush & state∈{IDLE,DONE}) | state∈{MUL,DIV,FIX}.
  - It is 0 in the DONE cycle, so the pipeline advances with result.
- Timing, with accept at edge T (done is high for exactly the one cycle after the edge listed):
  - Multiply: MUL for MUL_LATENCY-1 cycles, then DONE. done is high in the cycle following edge T+MUL_LATENCY-1. MUL_LATENCY=1 means done in the cycle right after accept.
  - Divide, normal: DIV runs XLEN iterations, then FIX applies sign correction, then DONE. done follows edge T+XLEN+1.
  - Divide by zero and signed overflow bypass DIV and go to DONE after the accept edge. done follows edge T.
- Multiply arithmetic:
  - The unit forms a 2·XLEN-bit product.
  - Operand signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide arithmetic:
  - The unit divides magnitudes as unsigned. A signed quotient is negated if the operand signs differ; a signed remainder takes the dividend's sign.
  - Divide by zero: quotient all ones (DIV and DIVU); remainder = src_a.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1, signed ops only): quotient = src_a; remainder = 0.
- DONE:
  - Lasts exactly one cycle, then the unit returns to IDLE unless a new op is accepted in that cycle. A back-to-back accept is legal.
- Flush:
  - flush=1 at any edge with state∈{MUL,DIV,FIX} forces IDLE at that edge. No done is produced; result keeps its prior value.
  - flush with start in the same cycle: flush wins and the op is not accepted.
  - flush in the DONE cycle: done still pulses, since the result was already produced.
- x0 and writeback are handled outside this block. The unit never inspects rd.

Test Plan:
- MULH vs MULHU: XLEN=32, MUL_LATENCY=2.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → result 0x00000000.
  - MULHU of the same operands → 0xFFFFFFFE.
  - MUL 0x12345678×0x10 → 0x23456780.
  - Each: done in the cycle after edge T+1; stall_req high in the accept cycle and the next cycle.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF.
  - done exactly after edge T+33; stall_req continuously high from the start cycle until done.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. done after edge T (single stall cycle).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. done after edge T.
- Flush mid-divide:
  - Start DIVU 100/7, then assert flush at edge T+10.
  - Required: no done pulse, stall_req=0 from T+10, result unchanged.
  - Then start DIVU 100/7 again → 14; REMU → 2 with normal latency.
- Reset and back-to-back:
  - Drop rst_n mid-MULHU → done=0, result=0, stall_req=0 immediately.
  - Release rst_n, then issue MUL 3×4 with another MUL 5×6 accepted in its DONE cycle → results 12 then 30 on consecutive done pulses.
